// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - MIPS instruction fetch and decode front end for the multicycle control FSM
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CMD_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_data,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm16,
    output logic [31:0]      imm_sext,
    output logic [31:0]      jtarget,
    output logic [31:0]      pc_cur,
    output logic [31:0]      pc_plus4,
    input  logic             exec_done,
    input  logic             pc_load,
    input  logic [31:0]      pc_next,
    output logic             illegal
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_ISSUE, S_EXECUTE, S_TRAP} state_t;

    localparam logic [CMD_W-1:0] CMD_LW      = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_SW      = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_J       = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_JR      = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_JAL     = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_BNE     = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_XORI    = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_ADD     = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_ADDI    = CMD_W'(8);
    localparam logic [CMD_W-1:0] CMD_SUB     = CMD_W'(9);
    localparam logic [CMD_W-1:0] CMD_SLT     = CMD_W'(10);
    localparam logic [CMD_W-1:0] CMD_ILLEGAL = CMD_W'(15);

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              imem_req_q, imem_req_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              illegal_q, illegal_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [15:0]       imm16_q, imm16_d;
    logic [31:0]       imm_sext_q, imm_sext_d;
    logic [31:0]       jtarget_q, jtarget_d;
    logic [CMD_W-1:0]  dec_cmd;
    logic [31:0]       pc_inc;
    logic              unused_pc_next_lsbs;

    assign pc_inc              = pc_q + 32'd4;
    assign unused_pc_next_lsbs = ^pc_next[1:0];

    always_comb begin
        dec_cmd = CMD_ILLEGAL;
        case (ir_q[31:26])
            6'h23: dec_cmd = CMD_LW;
            6'h2B: dec_cmd = CMD_SW;
            6'h02: dec_cmd = CMD_J;
            6'h03: dec_cmd = CMD_JAL;
            6'h05: dec_cmd = CMD_BNE;
            6'h0E: dec_cmd = CMD_XORI;
            6'h08: dec_cmd = CMD_ADDI;
            6'h00: begin
                case (ir_q[5:0])
                    6'h08:   dec_cmd = CMD_JR;
                    6'h20:   dec_cmd = CMD_ADD;
                    6'h22:   dec_cmd = CMD_SUB;
                    6'h2A:   dec_cmd = CMD_SLT;
                    default: dec_cmd = CMD_ILLEGAL;
                endcase
            end
            default: dec_cmd = CMD_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        cmd_d      = cmd_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        imm16_d    = imm16_q;
        imm_sext_d = imm_sext_q;
        jtarget_d  = jtarget_q;
        case (state_q)
            S_FETCH: begin
                // Only an ack to a request already on the bus is taken.
                if (imem_req_q && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cmd_d      = dec_cmd;
                rs_d       = ir_q[25:21];
                rt_d       = ir_q[20:16];
                rd_d       = ir_q[15:11];
                imm16_d    = ir_q[15:0];
                imm_sext_d = {{16{ir_q[15]}}, ir_q[15:0]};
                jtarget_d  = {pc_inc[31:28], ir_q[25:0], 2'b00};
                if (dec_cmd == CMD_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (exec_done) begin
                    pc_d    = pc_load ? {pc_next[31:2], 2'b00} : pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        imem_req_d  = (state_d == S_FETCH);
        cmd_valid_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_FETCH;
            pc_q        <= {RESET_PC[31:2], 2'b00};
            ir_q        <= '0;
            imem_req_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            cmd_q       <= CMD_ILLEGAL;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm16_q     <= '0;
            imm_sext_q  <= '0;
            jtarget_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            imem_req_q  <= imem_req_d;
            cmd_valid_q <= cmd_valid_d;
            illegal_q   <= illegal_d;
            cmd_q       <= cmd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            imm16_q     <= imm16_d;
            imm_sext_q  <= imm_sext_d;
            jtarget_q   <= jtarget_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign rd        = rd_q;
    assign imm16     = imm16_q;
    assign imm_sext  = imm_sext_q;
    assign jtarget   = jtarget_q;
    assign pc_cur    = pc_q;
    assign pc_plus4  = pc_inc;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - directed vector bench for instr_fetch_decode
module tb_instr_fetch_decode;
    logic        clk = 1'b0;
    logic        reset_n, imem_req, imem_ack, cmd_valid, cmd_ready;
    logic        exec_done, pc_load, illegal;
    logic [31:0] imem_addr, imem_data, imm_sext, jtarget, pc_cur, pc_plus4, pc_next;
    logic [3:0]  cmd;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_decode #(.RESET_PC(32'h0000_0000), .CMD_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
        .imm_sext(imm_sext), .jtarget(jtarget), .pc_cur(pc_cur), .pc_plus4(pc_plus4),
        .exec_done(exec_done), .pc_load(pc_load), .pc_next(pc_next), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  cmd;
        logic [4:0]  rs, rt, rd;
        logic [31:0] sext;
        int          stall;
        bit          early;
        bit          load;
        logic [31:0] next;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fetch_issue(input logic [31:0] instr, input logic [31:0] exp_pc);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", imem_req, 1);
        chk("imem_addr", imem_addr, exp_pc);
        imem_data = instr;
        imem_ack  = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("req_drop", imem_req, 0);
        chk("valid_early", cmd_valid, 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, p4, exp_jt, ins;
        vecs[0]  = '{32'h8C22_0004, 4'd0,  5'd1,  5'd2, 5'd0, 32'h0000_0004, 0, 0, 0, 32'h0};
        vecs[1]  = '{32'h0043_0820, 4'd7,  5'd2,  5'd3, 5'd1, 32'h0000_0820, 5, 1, 0, 32'h0};
        vecs[2]  = '{32'h1422_FFFF, 4'd5,  5'd1,  5'd2, 5'd31, 32'hFFFF_FFFF, 0, 0, 1, 32'h0000_0013};
        vecs[3]  = '{32'h0043_0822, 4'd9,  5'd2,  5'd3, 5'd1, 32'h0000_0822, 1, 0, 0, 32'h0};
        vecs[4]  = '{32'h0043_082A, 4'd10, 5'd2,  5'd3, 5'd1, 32'h0000_082A, 0, 0, 0, 32'h0};
        vecs[5]  = '{32'hAC22_FFF8, 4'd1,  5'd1,  5'd2, 5'd31, 32'hFFFF_FFF8, 0, 0, 0, 32'h0};
        vecs[6]  = '{32'h3822_00FF, 4'd6,  5'd1,  5'd2, 5'd0, 32'h0000_00FF, 0, 0, 0, 32'h0};
        vecs[7]  = '{32'h2022_8000, 4'd8,  5'd1,  5'd2, 5'd16, 32'hFFFF_8000, 2, 0, 0, 32'h0};
        vecs[8]  = '{32'h0C00_0003, 4'd4,  5'd0,  5'd0, 5'd0, 32'h0000_0003, 0, 0, 0, 32'h0};
        vecs[9]  = '{32'h03E0_0008, 4'd3,  5'd31, 5'd0, 5'd0, 32'h0000_0008, 0, 0, 1, 32'hFFFF_FFFF};
        vecs[10] = '{32'h0800_0001, 4'd2,  5'd0,  5'd0, 5'd0, 32'h0000_0001, 0, 0, 0, 32'h0};

        reset_n = 1'b0; imem_ack = 1'b0; imem_data = '0; cmd_ready = 1'b0;
        exec_done = 1'b0; pc_load = 1'b0; pc_next = '0;
        repeat (2) @(negedge clk);
        chk("rst_cmd", cmd, 4'hF);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_rs", rs, 0);
        chk("rst_sext", imm_sext, 0);
        chk("rst_jtarget", jtarget, 0);
        chk("rst_pc", pc_cur, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);

        pc = 32'h0;
        for (int i = 0; i < 11; i++) begin
            ins = vecs[i].instr;
            p4  = pc + 32'd4;
            exp_jt = {p4[31:28], ins[25:0], 2'b00};
            fetch_issue(ins, pc);
            chk("valid", cmd_valid, 1);
            chk("cmd", cmd, vecs[i].cmd);
            chk("rs", rs, vecs[i].rs);
            chk("rt", rt, vecs[i].rt);
            chk("rd", rd, vecs[i].rd);
            chk("imm16", imm16, {16'h0, ins[15:0]});
            chk("imm_sext", imm_sext, vecs[i].sext);
            chk("jtarget", jtarget, exp_jt);
            chk("pc_cur", pc_cur, pc);
            chk("pc_plus4", pc_plus4, p4);
            for (int s = 0; s < vecs[i].stall; s++) begin
                exec_done = 1'b1;
                @(negedge clk);
                exec_done = 1'b0;
                chk("stall_valid", cmd_valid, 1);
                chk("stall_cmd", cmd, vecs[i].cmd);
                chk("stall_sext", imm_sext, vecs[i].sext);
                chk("stall_addr", imem_addr, pc);
            end
            cmd_ready = 1'b1;
            exec_done = vecs[i].early;
            @(negedge clk);
            cmd_ready = 1'b0;
            exec_done = 1'b0;
            chk("valid_drop", cmd_valid, 0);
            @(negedge clk);
            chk("exec_req", imem_req, 0);
            chk("exec_cmd", cmd, vecs[i].cmd);
            exec_done = 1'b1;
            pc_load   = vecs[i].load;
            pc_next   = vecs[i].next;
            @(negedge clk);
            exec_done = 1'b0;
            pc_load   = 1'b0;
            pc = vecs[i].load ? {vecs[i].next[31:2], 2'b00} : pc + 32'd4;
            chk("next_req", imem_req, 1);
            chk("next_addr", imem_addr, pc);
        end

        // illegal opcode traps until reset
        fetch_issue(32'hFC00_0000, 32'h0);
        for (int c = 0; c < 20; c++) begin
            chk("trap_req", imem_req, 0);
            chk("trap_valid", cmd_valid, 0);
            chk("trap_illegal", illegal, 1);
            chk("trap_cmd", cmd, 4'hF);
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("trap_rst_illegal", illegal, 0);
        chk("trap_rst_cmd", cmd, 4'hF);
        @(negedge clk);
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 0);

        // reset while issuing, with a stray ack
        fetch_issue(32'h8C22_0004, 32'h0);
        chk("pre_valid", cmd_valid, 1);
        reset_n = 1'b0; imem_ack = 1'b1; imem_data = 32'h0043_0820;
        @(negedge clk);
        reset_n = 1'b1; imem_ack = 1'b0;
        chk("mid_valid", cmd_valid, 0);
        chk("mid_cmd", cmd, 4'hF);
        chk("mid_rs", rs, 0);
        chk("mid_req", imem_req, 0);

        // advance PC to 4, then reset during the pending fetch
        fetch_issue(32'h0043_0822, 32'h0);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("f_addr", imem_addr, 32'h4);
        reset_n = 1'b0; imem_ack = 1'b1; imem_data = 32'h0043_0820;
        @(negedge clk);
        reset_n = 1'b1; imem_ack = 1'b0;
        chk("f_rst_pc", pc_cur, 0);
        chk("f_rst_req", imem_req, 0);
        @(negedge clk);
        chk("f_rst_valid", cmd_valid, 0);
        fetch_issue(32'h0043_082A, 32'h0);
        chk("post_valid", cmd_valid, 1);
        chk("post_cmd", cmd, 4'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
